// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the logic unit pipeline: opcodes, FSM encoding and
// the single-bit logic function used by both elementwise and reduce modes.
package logic_unit_pipe_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // x is the "other" operand (b_in or the accumulator); y is always a_in,
  // so the unary ops NOT and PASS act on a_in in both modes.
  function automatic logic bit_op(logic [2:0] op, logic x, logic y);
    logic r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOT:  r = ~y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      default: r = y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle between the producer/consumer and the logic unit.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [2:0]       op_in;
  logic             reduce_in;
  logic             last_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] y_out;
  logic             zero_out;
  logic             parity_out;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output a_in, b_in, op_in, reduce_in, last_in, valid_in, ready_in,
    input  ready_out, y_out, zero_out, parity_out, cnt_out, ovf_out, valid_out
  );

  modport slave (
    input  a_in, b_in, op_in, reduce_in, last_in, valid_in, ready_in,
    output ready_out, y_out, zero_out, parity_out, cnt_out, ovf_out, valid_out
  );
endinterface

// File: rtl/logic_unit_pipe_op.sv
// Purely combinational WIDTH-bit bitwise logic operation.
module logic_unit_op
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res
);

  // Apply the per-bit function across the whole word.
  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = bit_op(op, x[i], y[i]);
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready on both sides and a multi-beat
// reduce mode that folds a burst of a_in values into a single result.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | no burst open; beats are elementwise or open a burst
//   ST_ACC  | reduce burst open; beats fold into acc with latched op
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic          clk_in,
  input logic          rst_n_in,
  logic_unit_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt_acc;
  logic             ovf_acc;
  logic [2:0]       op_q;

  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             valid_q;

  logic             ready;
  logic             accept;
  logic             take;
  logic             in_acc;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] op_res;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_inc;

  assign in_acc = (state == ST_ACC);
  assign ready  = !valid_q || bus.ready_in;
  assign accept = bus.valid_in && ready;
  assign take   = valid_q && bus.ready_in;

  // One operator serves both modes: b_in op a_in, or acc op a_in in a burst.
  assign op_sel = in_acc ? op_q : bus.op_in;
  assign x_sel  = in_acc ? acc  : bus.b_in;

  // Count saturates; overflow flags any beat that arrived with the count full.
  assign cnt_inc = (cnt_acc == CNT_MAX) ? cnt_acc : cnt_acc + CNT_ONE;
  assign ovf_inc = ovf_acc || (cnt_acc == CNT_MAX);

  logic_unit_op #(.WIDTH(WIDTH)) u_op (
    .op  (op_sel),
    .x   (x_sel),
    .y   (bus.a_in),
    .res (op_res)
  );

  // FSM, accumulator and registered result/status; a take and a publish in
  // the same cycle leave valid set with the new result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt_acc <= '0;
      ovf_acc <= 1'b0;
      op_q    <= OP_AND;
      y_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (take) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (!bus.reduce_in) begin
              y_q     <= op_res;
              cnt_q   <= CNT_ONE;
              ovf_q   <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              op_q    <= bus.op_in;
              acc     <= bus.a_in;
              cnt_acc <= CNT_ONE;
              ovf_acc <= 1'b0;
              if (bus.last_in) begin
                y_q     <= bus.a_in;
                cnt_q   <= CNT_ONE;
                ovf_q   <= 1'b0;
                valid_q <= 1'b1;
              end else begin
                state <= ST_ACC;
              end
            end
          end
          ST_ACC: begin
            acc     <= op_res;
            cnt_acc <= cnt_inc;
            ovf_acc <= ovf_inc;
            if (bus.last_in) begin
              y_q     <= op_res;
              cnt_q   <= cnt_inc;
              ovf_q   <= ovf_inc;
              valid_q <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ready_out  = ready;
  assign bus.y_out      = y_q;
  assign bus.cnt_out    = cnt_q;
  assign bus.ovf_out    = ovf_q;
  assign bus.valid_out  = valid_q;
  assign bus.zero_out   = ~|y_q;
  assign bus.parity_out = ^y_q;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the team's single-bit gate block: applies one of eight bitwise logic operations to WIDTH-bit operands, with a valid/ready handshake on both sides and a multi-beat reduce mode that folds a stream of operands into one result. It sits between a streaming producer and consumer in the datapath. Per-result zero, parity and beat-count status accompanies each result.

## Interface
- WIDTH, 8: operand and result width in bits (≥1).
- CNT_W, 4: beat-counter width; counts saturate at 2^CNT_W−1.
- clk_in  input  1  clock; all state changes on rising edge.
- rst_n_in  input  1  reset, asynchronous and active-low.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B; ignored in reduce mode.
- op_in  input  3  opcode: 0 AND, 1 OR, 2 NOT(A), 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS(A).
- reduce_in  input  1  1 = reduce mode; 0 = elementwise.
- last_in  input  1  final beat of a reduce burst; ignored in elementwise mode.
- valid_in  input  1  input beat valid.
- ready_out  output  1  block can accept a beat.
- y_out  output  WIDTH  result.
- zero_out  output  1  y_out is all zeros.
- parity_out  output  1  XOR of all y_out bits.
- cnt_out  output  CNT_W  beats folded into y_out (1 in elementwise mode).
- ovf_out  output  1  beat count saturated during this burst.
- valid_out  output  1  result valid.
- ready_in  input  1  consumer accepts result.

## Operation
- Beat accepted when valid_in && ready_out; result taken when valid_out && ready_in.
- ready_out = !valid_out || ready_in, in every state.
- FSM states: IDLE (no burst open), ACC (reduce burst open).
- IDLE, accepted beat, reduce_in=0: y ← a_in op b_in; cnt=1; ovf=0; valid_out set. Stay IDLE.
- IDLE, accepted beat, reduce_in=1: op_in latched for the burst; acc ← a_in; cnt=1. last_in=1 → publish acc, stay IDLE; else → ACC.
- ACC, accepted beat: acc ← acc op a_in using the latched op (NOT: acc ← ~a_in; PASS: acc ← a_in); cnt increments, saturating, ovf sticky on saturation. last_in=1 → publish, → IDLE. op_in and reduce_in ignored in ACC.
- Publishing loads y_out, cnt_out, ovf_out and sets valid_out; zero_out and parity_out derive combinationally from the registered y_out.
- valid_out clears on result taken with no new publish in the same cycle; a taken result and a new publish in the same cycle load the new result, valid_out stays 1.
- Outputs stable while valid_out && !ready_in.
- Reset (async assert, any state): FSM → IDLE, acc = 0, y_out = 0, cnt_out = 0, ovf_out = 0, valid_out = 0; therefore zero_out = 1, parity_out = 0, ready_out = 1. An open burst is discarded; no partial result emitted.

## Timing
- Elementwise latency: 1 cycle (beat accepted at edge k, valid_out high after edge k).
- Reduce latency: result valid 1 cycle after the last_in beat is accepted.
- Throughput: one beat per cycle while ready_in=1; back-to-back results with no bubble.
- Back-pressure: ready_in=0 with valid_out=1 drops ready_out the same cycle (combinational path ready_in→ready_out).
- Idle cycles (valid_in=0) inside a burst are allowed; ACC holds.
- Reset deassertion synchronous to clk_in is the integrator's responsibility.

## Structure
- Shared package: opcode localparams (OP_AND … OP_PASS), FSM state encoding (ST_IDLE, ST_ACC), and the bitwise-op function used by both modes.
- One sub-module is natural: logic_unit_op, purely combinational (op, x, y → WIDTH result), instantiated once with its first operand muxed between b_in (elementwise) and acc (reduce).

## Test plan
- Reset then elementwise, WIDTH=8: a=0xF0, b=0x3C, ops 0–7 back-to-back, ready_in=1 → y = 0x30, 0xFC, 0x0F, 0xCC, 0xCF, 0x03, 0x33, 0xF0, each 1 cycle after acceptance, cnt=1.
- Reduce XOR burst a = 0x01, 0x02, 0x04, last on 3rd → single result y=0x07, cnt=3, parity=1, zero=0.
- Reduce AND single beat with last_in=1, a=0xA5 → y=0xA5, cnt=1, next cycle.
- CNT_W=2, reduce OR 5 beats of 0x00 → y=0x00, zero=1, cnt=3, ovf=1.
- ready_in held 0 for 4 cycles after a result → ready_out=0, y_out stable; release with valid_in high → old result taken and new one loaded in same cycle, valid_out stays 1.
- rst_n_in asserted mid-burst (after 2 of 4 beats) → valid_out=0, y_out=0, cnt_out=0 immediately; next burst of 2 beats reports cnt=2 with no carry-over.
